// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel programmable 50%-duty clock divider
// Each channel: posedge counter FSM plus a negedge half-cycle flop for odd ratios.
module clk_div_multi #(
   parameter int WIDTH  = 8,
   parameter int NUM_CH = 2
) (
   input  logic                    Ref_Clk,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       en,
   input  logic [NUM_CH*WIDTH-1:0] div_ratio,
   output logic [NUM_CH-1:0]       clk_out,
   output logic [NUM_CH-1:0]       tick,
   output logic [NUM_CH-1:0]       active,
   output logic [NUM_CH-1:0]       ratio_err
);

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      state_t           state_q, state_d;
      logic [WIDTH-1:0] cnt_q, cnt_d;
      logic [WIDTH-1:0] ns_q, ns_d;
      logic [WIDTH-1:0] ld_ratio, ld_ns, cnt_inc;
      logic             pos_q, pos_d;
      logic             neg_q;
      logic             tick_q, tick_d;
      logic             err_q, err_d;
      logic             ld_bad, at_end;

      assign ld_ratio = div_ratio[i*WIDTH +: WIDTH];
      assign ld_bad   = ld_ratio < WIDTH'(2);
      assign ld_ns    = ld_bad ? WIDTH'(2) : ld_ratio;
      assign cnt_inc  = cnt_q + WIDTH'(1);
      assign at_end   = (cnt_q == ns_q - WIDTH'(1));

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         ns_d    = ns_q;
         pos_d   = pos_q;
         tick_d  = 1'b0;
         err_d   = err_q;
         case (state_q)
            ST_IDLE: begin
               cnt_d = '0;
               pos_d = 1'b0;
               if (en[i]) begin
                  state_d = ST_RUN;
                  ns_d    = ld_ns;
                  err_d   = ld_bad;
                  pos_d   = 1'b1;
                  tick_d  = 1'b1;
               end
            end
            ST_RUN: begin
               if (at_end) begin
                  cnt_d = '0;
                  if (en[i]) begin
                     ns_d   = ld_ns;
                     err_d  = ld_bad;
                     pos_d  = 1'b1;
                     tick_d = 1'b1;
                  end else begin
                     // Stop only at the boundary so the last period is never cut short.
                     state_d = ST_IDLE;
                     pos_d   = 1'b0;
                     err_d   = 1'b0;
                  end
               end else begin
                  cnt_d = cnt_inc;
                  pos_d = (cnt_inc < (ns_q >> 1));
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      always_ff @(posedge Ref_Clk or negedge rst) begin
         if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ns_q    <= WIDTH'(2);
            pos_q   <= 1'b0;
            tick_q  <= 1'b0;
            err_q   <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ns_q    <= ns_d;
            pos_q   <= pos_d;
            tick_q  <= tick_d;
            err_q   <= err_d;
         end
      end

      // Stretches the high phase by half a cycle for odd ratios.
      always_ff @(negedge Ref_Clk or negedge rst) begin
         if (!rst) neg_q <= 1'b0;
         else      neg_q <= pos_q & ns_q[0];
      end

      assign clk_out[i]   = pos_q | neg_q;
      assign tick[i]      = tick_q;
      assign active[i]    = (state_q == ST_RUN);
      assign ratio_err[i] = err_q;
   end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - directed self-checking bench for clk_div_multi
module tb_clk_div_multi;

   logic        Ref_Clk;
   logic        rst;
   logic [1:0]  en;
   logic [15:0] div_ratio;
   logic [1:0]  clk_out;
   logic [1:0]  tick;
   logic [1:0]  active;
   logic [1:0]  ratio_err;

   int n_chk;
   int n_err;

   logic [31:0] pv [2];
   logic [31:0] nv [2];
   logic [31:0] tv [2];
   logic [31:0] av [2];
   logic [31:0] ev [2];

   clk_div_multi #(.WIDTH(8), .NUM_CH(2)) dut (
      .Ref_Clk   (Ref_Clk),
      .rst       (rst),
      .en        (en),
      .div_ratio (div_ratio),
      .clk_out   (clk_out),
      .tick      (tick),
      .active    (active),
      .ratio_err (ratio_err)
   );

   initial Ref_Clk = 1'b0;
   always #5 Ref_Clk = ~Ref_Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_ratio(input int ch, input logic [7:0] val);
      div_ratio[ch*8 +: 8] = val;
   endtask

   // Bit k of each vector is cycle k after the next posedge; nv samples after the negedge.
   task automatic capture(input int n);
      for (int c = 0; c < 2; c++) begin
         pv[c] = '0; nv[c] = '0; tv[c] = '0; av[c] = '0; ev[c] = '0;
      end
      for (int k = 0; k < n; k++) begin
         @(posedge Ref_Clk); #1;
         for (int c = 0; c < 2; c++) begin
            pv[c][k] = clk_out[c];
            tv[c][k] = tick[c];
            av[c][k] = active[c];
            ev[c][k] = ratio_err[c];
         end
         @(negedge Ref_Clk); #1;
         for (int c = 0; c < 2; c++) nv[c][k] = clk_out[c];
      end
   endtask

   task automatic hold_reset(input logic [1:0] en_v, input logic [7:0] r0, input logic [7:0] r1);
      rst = 1'b0;
      en  = en_v;
      set_ratio(0, r0);
      set_ratio(1, r1);
      repeat (3) @(posedge Ref_Clk);
      #1;
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      rst = 1'b0;
      en = 2'b00;
      div_ratio = '0;

      // Reset state, with en already asserted: outputs must stay quiet.
      hold_reset(2'b01, 8'd4, 8'd2);
      chk("rst_clk_out", clk_out, 32'h0);
      chk("rst_tick", tick, 32'h0);
      chk("rst_active", active, 32'h0);
      chk("rst_ratio_err", ratio_err, 32'h0);
      rst = 1'b1;

      // N=4 from first posedge
      capture(8);
      chk("n4_pos", pv[0], 32'h33);
      chk("n4_neg", nv[0], 32'h33);
      chk("n4_tick", tv[0], 32'h11);
      chk("n4_active", av[0], 32'hFF);
      chk("n4_err", ev[0], 32'h00);
      chk("n4_ch1_idle", av[1] | pv[1], 32'h00);

      // Mid-period ratio change 4 -> 6 at cnt=1
      capture(2);
      chk("chg_pre", pv[0], 32'h3);
      set_ratio(0, 8'd6);
      capture(14);
      chk("chg_pos", pv[0], 32'h71C);
      chk("chg_neg", nv[0], 32'h71C);
      chk("chg_tick", tv[0], 32'h104);

      // Stop at cnt=1 of N=6, then re-enable
      capture(2);
      chk("stop_pre", pv[0], 32'h3);
      en[0] = 1'b0;
      capture(8);
      chk("stop_pos", pv[0], 32'h01);
      chk("stop_tick", tv[0], 32'h00);
      chk("stop_active", av[0], 32'h0F);
      en[0] = 1'b1;
      capture(6);
      chk("reen_pos", pv[0], 32'h07);
      chk("reen_tick", tv[0], 32'h01);
      chk("reen_active", av[0], 32'h3F);

      // Odd ratios N=5 then N=3
      hold_reset(2'b01, 8'd5, 8'd2);
      rst = 1'b1;
      capture(10);
      chk("n5_pos", pv[0], 32'hE7);
      chk("n5_neg", nv[0], 32'h63);
      chk("n5_tick", tv[0], 32'h21);
      set_ratio(0, 8'd3);
      capture(6);
      chk("n3_pos", pv[0], 32'h1B);
      chk("n3_neg", nv[0], 32'h09);

      // Clamp on ch1: N=0 at enable, N=8 at boundary, N=1 at boundary
      hold_reset(2'b10, 8'd4, 8'd0);
      rst = 1'b1;
      capture(4);
      chk("n0_pos", pv[1], 32'h5);
      chk("n0_neg", nv[1], 32'h5);
      chk("n0_tick", tv[1], 32'h5);
      chk("n0_err", ev[1], 32'hF);
      chk("n0_ch0_idle", av[0] | pv[0], 32'h0);
      set_ratio(1, 8'd8);
      capture(8);
      chk("n8_pos", pv[1], 32'h0F);
      chk("n8_err", ev[1], 32'h00);
      chk("n8_tick", tv[1], 32'h01);
      set_ratio(1, 8'd1);
      capture(4);
      chk("n1_pos", pv[1], 32'h5);
      chk("n1_err", ev[1], 32'hF);

      // Both channels enabled on the same edge: N=2 and N=7
      hold_reset(2'b11, 8'd2, 8'd7);
      rst = 1'b1;
      capture(14);
      chk("mc_ch0_pos", pv[0], 32'h1555);
      chk("mc_ch0_tick", tv[0], 32'h1555);
      chk("mc_ch1_pos", pv[1], 32'h78F);
      chk("mc_ch1_neg", nv[1], 32'h387);
      chk("mc_ch1_tick", tv[1], 32'h81);

      // Asynchronous reset mid-cycle
      @(posedge Ref_Clk); #2;
      chk("pre_rst_clk_out", clk_out, 32'h3);
      chk("pre_rst_tick", tick, 32'h3);
      rst = 1'b0;
      #1;
      chk("async_rst_clk_out", clk_out, 32'h0);
      chk("async_rst_tick", tick, 32'h0);
      chk("async_rst_active", active, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Multi-channel programmable clock divider for the TX PLL clock tree. Derives NUM_CH independent divided clocks from Ref_Clk.
- Each channel supports any integer ratio N ≥ 2, odd or even, at 50% duty.
- Ratio changes apply glitch-free at period boundaries. Each channel has a clean enable/stop.
- Each channel emits a one-cycle tick aligned to every rising edge of its divided clock, for downstream PCLK-domain sequencing.

Parameters:
- WIDTH, 8, bit width of each channel's divide ratio and counter.
- NUM_CH, 2, number of independent divider channels.

Ports:
- Ref_Clk  input  1  reference clock; all state updates on its posedge, except the odd-ratio half-cycle flop (negedge).
- rst  input  1  asynchronous, active-low reset.
- en  input  NUM_CH  per-channel run enable, sampled on Ref_Clk posedge.
- div_ratio  input  NUM_CH*WIDTH  per-channel ratio N; channel i uses bits [i*WIDTH +: WIDTH].
- clk_out  output  NUM_CH  divided clocks.
- tick  output  NUM_CH  one-Ref_Clk-cycle pulse, high in the cycle each clk_out rises.
- active  output  NUM_CH  channel running.
- ratio_err  output  NUM_CH  high while the channel runs with a clamped (invalid) ratio.

Behaviour:
- Per-channel state: cnt[WIDTH-1:0], shadow ratio Ns, odd flag, pos_q (posedge flop), neg_q (negedge flop), tick, active, ratio_err.
- Reset (rst=0, async): cnt=0, Ns=2, pos_q=0, neg_q=0, clk_out=0, tick=0, active=0, ratio_err=0. All channels are IDLE.
- Ratio sampling:
  - div_ratio is sampled into Ns only at a load edge: IDLE→RUN start, or a period boundary.
  - Ratio changes mid-period are ignored until the next boundary; the current period always completes at its old length.
  - Values 0 or 1 are clamped to Ns=2 and set ratio_err=1 at that load; a valid load clears ratio_err.
- Per-ratio derived values:
  - odd = Ns[0].
  - High threshold H = Ns>>1 for both even and odd Ns (equals (Ns-1)/2 for odd).
- IDLE, en=1 sampled (load edge):
  - Load Ns; cnt<=0, pos_q<=1, tick<=1, active<=1.
  - State goes to RUN; clk_out rises immediately after that edge.
- RUN, cnt==Ns-1 (period boundary), en=1:
  - Reload Ns; cnt<=0, pos_q<=1, tick<=1.
- RUN, cnt==Ns-1, en=0:
  - cnt<=0, pos_q<=0, tick<=0, active<=0; go IDLE.
  - The last period is always completed; no runt pulse.
- RUN, otherwise:
  - cnt<=cnt+1, pos_q<=((cnt+1)<H), tick<=0.
  - en deasserted mid-period has no effect until the boundary.
- neg_q: on Ref_Clk negedge, neg_q<=pos_q & odd; async-reset to 0.
- clk_out = pos_q | neg_q.
  - Even Ns: neg_q=0, so clk_out is high for Ns/2 cycles and low for Ns/2 cycles.
  - Odd Ns: clk_out is high for (Ns-1)/2 + ½ cycles and low for the rest; period is Ns cycles.
  - The OR of overlapping flops is glitch-free.
- tick is registered, high exactly the Ref_Clk cycle following each clk_out rising edge event (same edge as the pos_q rise).
- Counter width: Ns up to 2^WIDTH-1 supported; cnt never exceeds Ns-1; no overflow.
- Channels are fully independent; there is no phase relation unless they are enabled on the same edge, in which case rising edges align.
- Reset mid-period: all outputs drop to reset values asynchronously. After release, a channel with en=1 starts at the first posedge.

Test Plan:
- Reset/enable: rst low 3 cycles then high, en[0]=1, N=4 → clk_out[0] rises after the first posedge; period 4 cycles, high 2; tick[0] once per 4 cycles; active[0]=1.
- Odd ratio: N=5 → period 5 Ref_Clk, high 2.5 cycles (falls on negedge), low 2.5; N=3 → 1.5/1.5.
- Ratio change mid-period: N=4 running, write N=6 at cnt=1 → current period ends at 4 cycles; the next period is 6 cycles, high 3; no glitch.
- Clamp: N=0 and N=1 at enable → behaves as N=2 (toggles every cycle); ratio_err=1. Then load N=8 at a boundary → ratio_err=0, period 8.
- Stop: en low at cnt=1 of N=6 → clk_out completes its high phase and low phase to the 6-cycle boundary, then holds 0; active falls at the boundary; re-enable restarts at cnt=0 with tick.
- Multi-channel/async reset: ch0 N=2, ch1 N=7 enabled on the same edge → aligned first rising edges, independent periods; assert rst mid-run → all clk_out/tick/active drop to 0 immediately.
